// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with shift/rotate/load/clear
// and a counted burst-shift engine reporting busy/done.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] pin,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] pout,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_ROR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       lat_q, lat_d;
    logic             done_q, done_d;
    logic             burst_ok;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] q,
        input logic             smsb,
        input logic             slsb,
        input logic [WIDTH-1:0] p
    );
        logic [WIDTH-1:0] r;
        r = q;
        unique case (m)
            M_SHR:   r = {smsb, q[WIDTH-1:1]};
            M_SHL:   r = {q[WIDTH-2:0], slsb};
            M_ROR:   r = {q[0], q[WIDTH-1:1]};
            M_ROL:   r = {q[WIDTH-2:0], q[WIDTH-1]};
            M_LOAD:  r = p;
            M_CLR:   r = '0;
            default: r = q;
        endcase
        return r;
    endfunction

    // Only the four shift/rotate modes may be run as a burst.
    assign burst_ok = (mode == M_SHR) || (mode == M_SHL) ||
                      (mode == M_ROR) || (mode == M_ROL);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (burst_start) begin
                    if (burst_ok) begin
                        lat_d = mode;
                        cnt_d = burst_len;
                        if (burst_len != '0) begin
                            state_d = BURST;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end else if (en) begin
                    q_d = apply_op(mode, q_q, sin_msb, sin_lsb, pin);
                end
            end
            BURST: begin
                if (en) begin
                    q_d   = apply_op(lat_q, q_q, sin_msb, sin_lsb, pin);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            lat_q   <= M_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            done_q  <= done_d;
        end
    end

    assign pout     = q_q;
    assign sout_lsb = q_q[0];
    assign sout_msb = q_q[WIDTH-1];
    assign busy     = (state_q == BURST);
    assign done     = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: vector table for single-edge
// operations plus hand-written burst, stall and reset sequences.
module tb_univ_shift_reg;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [2:0]   mode;
    logic         sin_msb;
    logic         sin_lsb;
    logic [W-1:0] pin;
    logic         burst_start;
    logic [C-1:0] burst_len;
    logic [W-1:0] pout;
    logic         sout_lsb;
    logic         sout_msb;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W), .CNT_W(C)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .sin_msb     (sin_msb),
        .sin_lsb     (sin_lsb),
        .pin         (pin),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .pout        (pout),
        .sout_lsb    (sout_lsb),
        .sout_msb    (sout_msb),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic         en;
        logic [2:0]   mode;
        logic         smsb;
        logic         slsb;
        logic [W-1:0] pin;
        logic [W-1:0] exp_q;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string name, input logic [W-1:0] q,
                          input logic b, input logic d);
        chk({name, ".pout"}, 32'(pout), 32'(q));
        chk({name, ".busy"}, 32'(busy), 32'(b));
        chk({name, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic load(input logic [W-1:0] v);
        en = 1'b1;
        burst_start = 1'b0;
        mode = 3'b101;
        pin = v;
        step();
        mode = 3'b000;
        chk("load", 32'(pout), 32'(v));
    endtask

    task automatic add(input logic e, input logic [2:0] m,
                       input logic sm, input logic sl,
                       input logic [W-1:0] p, input logic [W-1:0] q);
        vec_t v;
        v.en = e; v.mode = m; v.smsb = sm; v.slsb = sl;
        v.pin = p; v.exp_q = q;
        vt.push_back(v);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 3'b000;
        sin_msb = 1'b0; sin_lsb = 1'b0; pin = '0;
        burst_start = 1'b0; burst_len = '0;

        add(1, 3'b101, 0, 0, 8'hA5, 8'hA5);
        add(1, 3'b000, 0, 0, 8'h00, 8'hA5);
        add(0, 3'b110, 0, 0, 8'h00, 8'hA5);
        add(1, 3'b101, 0, 0, 8'h81, 8'h81);
        add(1, 3'b011, 0, 0, 8'h00, 8'hC0);
        add(1, 3'b101, 0, 0, 8'h81, 8'h81);
        add(1, 3'b100, 0, 0, 8'h00, 8'h03);
        add(1, 3'b100, 0, 0, 8'h00, 8'h06);
        add(1, 3'b101, 0, 0, 8'h00, 8'h00);
        add(1, 3'b001, 1, 0, 8'h00, 8'h80);
        add(1, 3'b001, 0, 0, 8'h00, 8'h40);
        add(1, 3'b001, 1, 0, 8'h00, 8'hA0);
        add(1, 3'b001, 1, 0, 8'h00, 8'hD0);
        add(1, 3'b010, 0, 1, 8'h00, 8'hA1);
        add(1, 3'b010, 0, 1, 8'h00, 8'h43);
        add(1, 3'b010, 0, 1, 8'h00, 8'h87);
        add(1, 3'b110, 0, 0, 8'h00, 8'h00);
        add(1, 3'b111, 0, 0, 8'hFF, 8'h00);

        step();
        step();
        chk_st("reset", 8'h00, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            en = vt[i].en; mode = vt[i].mode;
            sin_msb = vt[i].smsb; sin_lsb = vt[i].slsb;
            pin = vt[i].pin;
            step();
            chk($sformatf("vec%0d", i), 32'(pout), 32'(vt[i].exp_q));
            chk($sformatf("vec%0d.msb", i), 32'(sout_msb),
                32'(vt[i].exp_q[W-1]));
            chk($sformatf("vec%0d.lsb", i), 32'(sout_lsb),
                32'(vt[i].exp_q[0]));
        end
        sin_msb = 1'b0; sin_lsb = 1'b0;

        // Reset in the middle of ordinary operation.
        load(8'hA5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_st("rst_mid", 8'h00, 0, 0);

        // Burst rotate-left x3, mode toggled during busy.
        load(8'h01);
        burst_start = 1'b1; mode = 3'b100; burst_len = 4'd3;
        step();
        chk_st("b_k", 8'h01, 1, 0);
        burst_start = 1'b0; mode = 3'b101; pin = 8'hFF;
        step();
        chk_st("b_k1", 8'h02, 1, 0);
        step();
        chk_st("b_k2", 8'h04, 1, 0);
        step();
        chk_st("b_k3", 8'h08, 0, 1);
        mode = 3'b000;
        step();
        chk_st("b_k4", 8'h08, 0, 0);

        // Same burst with two stalled cycles.
        load(8'h01);
        burst_start = 1'b1; mode = 3'b100; burst_len = 4'd3;
        step();
        burst_start = 1'b0; mode = 3'b000;
        step();
        chk_st("s_1", 8'h02, 1, 0);
        en = 1'b0;
        step();
        chk_st("s_st1", 8'h02, 1, 0);
        step();
        chk_st("s_st2", 8'h02, 1, 0);
        en = 1'b1;
        step();
        chk_st("s_2", 8'h04, 1, 0);
        step();
        chk_st("s_3", 8'h08, 0, 1);
        step();
        chk_st("s_4", 8'h08, 0, 0);

        // Zero-length burst.
        burst_start = 1'b1; mode = 3'b100; burst_len = 4'd0;
        step();
        chk_st("z_k", 8'h08, 0, 1);
        burst_start = 1'b0; mode = 3'b000;
        step();
        chk_st("z_k1", 8'h08, 0, 0);

        // burst_start with a non-shift mode is ignored entirely.
        burst_start = 1'b1; mode = 3'b101; pin = 8'hFF; burst_len = 4'd2;
        step();
        chk_st("inv", 8'h08, 0, 0);
        burst_start = 1'b0; mode = 3'b000;

        // Reset while busy with two shifts left.
        load(8'h01);
        burst_start = 1'b1; mode = 3'b100; burst_len = 4'd3;
        step();
        burst_start = 1'b0; mode = 3'b000;
        step();
        chk_st("r_b1", 8'h02, 1, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_st("r_rst", 8'h00, 0, 0);
        step();
        chk_st("r_idle", 8'h00, 0, 0);

        // Normal burst afterwards, then back-to-back burst at done.
        load(8'h01);
        burst_start = 1'b1; mode = 3'b011; burst_len = 4'd2;
        step();
        chk_st("n_k", 8'h01, 1, 0);
        burst_start = 1'b0; mode = 3'b000;
        step();
        chk_st("n_k1", 8'h80, 1, 0);
        step();
        chk_st("n_k2", 8'h40, 0, 1);
        burst_start = 1'b1; mode = 3'b011; burst_len = 4'd1;
        step();
        chk_st("bb_k", 8'h40, 1, 0);
        burst_start = 1'b0; mode = 3'b000;
        step();
        chk_st("bb_k1", 8'h20, 0, 1);
        step();
        chk_st("bb_k2", 8'h20, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; next generation of the team's fixed 4-bit serial-in/serial-out chain.
- Adds width parameter, parallel load/readout, bidirectional shift, rotate, clear, and a counted burst-shift engine with busy/done status.
- Used as a serialiser/deserialiser and bit-alignment stage in the lab datapaths.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of burst length field; max burst = 2^CNT_W-1 shifts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  clock enable for register operations; 0 = register and burst counter hold.
- mode  in  3  operation select (below).
- sin_msb  in  1  serial input entering at bit WIDTH-1 on shift right.
- sin_lsb  in  1  serial input entering at bit 0 on shift left.
- pin  in  WIDTH  parallel load data.
- burst_start  in  1  request a counted burst of the operation given by mode.
- burst_len  in  CNT_W  number of shifts in the burst.
- pout  out  WIDTH  register contents q.
- sout_lsb  out  1  q[0] (combinational from register).
- sout_msb  out  1  q[WIDTH-1] (combinational from register).
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse on burst completion.

Behaviour:
- Reset (reset=1 at rising edge, overrides everything): q=0, busy=0, done=0, internal count=0, latched mode=000. Reset mid-burst aborts the burst; no done pulse.
- Mode encoding, applied at an edge when en=1:
  - 000 hold.
  - 001 shift right: q <= {sin_msb, q[W-1:1]}.
  - 010 shift left: q <= {q[W-2:0], sin_lsb}.
  - 011 rotate right: q <= {q[0], q[W-1:1]}.
  - 100 rotate left: q <= {q[W-2:0], q[W-1]}.
  - 101 parallel load: q <= pin.
  - 110 clear: q <= 0.
  - 111 hold (reserved).
- en=0: q, count and busy hold. done still deasserts after its one cycle.
- States: IDLE, BURST.
- IDLE: mode is applied each edge with en=1. Serial inputs are sampled at that edge.
- Burst accept at edge k requires all of: IDLE, burst_start=1, mode in 001..100. Accept is independent of en.
  - At edge k: latch mode, count <= burst_len, q holds (burst_start has priority over mode).
  - If burst_len>0: go to BURST, busy=1.
  - If burst_len=0: stay IDLE, done=1 for the cycle after edge k.
- burst_start with mode outside 001..100 is ignored. No busy, no done; the mode itself is not executed that edge.
- BURST: mode input and burst_start are ignored. At each edge with en=1: apply latched operation, count decrements.
- When count reaches 0 (edge k+N for N shifts with no stalls): busy=0 and done=1 for exactly one cycle, then return to IDLE.
- A new burst_start may be accepted at the edge where done is high (back-to-back bursts allowed).
- done is never high at the same time as busy.
- Outputs pout/sout_* reflect q after each edge; no additional latency.

Test Plan:
- WIDTH=8. Reset, then mode=101, pin=8'hA5, en=1, one edge -> pout=8'hA5, sout_msb=1, sout_lsb=1. Assert reset mid-sequence -> pout=0 next edge.
- Load 8'h81; mode=011 for 1 edge -> 8'hC0. mode=100 for 2 edges from 8'h81 -> 8'h06.
- Load 8'h00; mode=001, sin_msb=1,0,1,1 on 4 edges -> pout=8'hD0. Then mode=010, sin_lsb=1 for 3 edges -> 8'h87.
- Load 8'h01; burst_start=1, mode=100, burst_len=3 at edge k.
  - busy=1 from k to k+3, falling after edge k+3; done=1 for only the cycle after edge k+3.
  - pout=8'h08.
  - Mode toggled to 101 during busy has no effect.
- Same burst with en=0 held for 2 cycles mid-burst -> completion delayed by 2 edges, final pout=8'h08. burst_len=0 -> done pulse after edge k, busy stays 0, pout unchanged.
- burst_start with mode=101 -> ignored, pout unchanged, busy/done stay 0.
- Reset asserted while busy=1 with count=2 -> busy=0, done=0, q=0. A subsequent burst behaves normally.
